reram_controller: RTL and testbench

//  Sequencer for one ReRAM crossbar inference pass (e.g. one 784->256 MLP layer).

---
 rtl/reram_controller.sv | 122 ++++++++++++
 tb/tb_reram_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/reram_controller.sv
// Sequencer for one ReRAM crossbar inference pass: streams input samples to the DAC,
// then steps the crossbar row by row and publishes each ADC result with its row index.
module reram_controller #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 12,
    parameter int unsigned INPUT_SIZE   = 784,
    parameter int unsigned OUTPUT_SIZE  = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    done,
    output logic                    busy,
    input  logic [INPUT_WIDTH-1:0]  input_data,
    input  logic                    input_valid,
    output logic                    input_ready,
    output logic [INPUT_WIDTH+1:0]  dac_out,
    output logic                    dac_valid,
    output logic                    xbar_enable,
    output logic [9:0]              xbar_addr,
    input  logic [OUTPUT_WIDTH-1:0] xbar_data,
    input  logic                    xbar_valid,
    output logic [OUTPUT_WIDTH-1:0] output_data,
    output logic [7:0]              output_addr,
    output logic                    output_valid
);

    localparam logic [9:0] LastIn  = 10'(INPUT_SIZE - 1);
    localparam logic [7:0] LastRow = 8'(OUTPUT_SIZE - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StCompute, StOutput, StDone} state_e;

    state_e                  state_q, state_d;
    logic [9:0]              in_cnt_q, in_cnt_d;
    logic [7:0]              row_q, row_d;
    logic [INPUT_WIDTH+1:0]  dac_q, dac_d;
    logic                    dac_valid_q, dac_valid_d;
    logic [OUTPUT_WIDTH-1:0] res_q, res_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_cnt_q    <= '0;
            row_q       <= '0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            row_q       <= row_d;
            dac_q       <= dac_d;
            dac_valid_q <= dac_valid_d;
            res_q       <= res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        row_d       = row_q;
        dac_d       = dac_q;
        dac_valid_d = 1'b0;
        res_d       = res_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StLoad;
                    in_cnt_d = '0;
                    row_d    = '0;
                end
            end
            StLoad: begin
                // input_ready is high for the whole of LOAD, so valid alone means accept
                if (input_valid) begin
                    dac_d       = {input_data, 2'b00};
                    dac_valid_d = 1'b1;
                    in_cnt_d    = in_cnt_q + 10'd1;
                    if (in_cnt_q == LastIn) begin
                        state_d = StCompute;
                    end
                end
            end
            StCompute: begin
                if (xbar_valid) begin
                    res_d   = xbar_data;
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (row_q == LastRow) begin
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 8'd1;
                    state_d = StCompute;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        xbar_addr = '0;
        case (state_q)
            StLoad:              xbar_addr = in_cnt_q;
            StCompute, StOutput: xbar_addr = {2'b00, row_q};
            default:             xbar_addr = '0;
        endcase
    end

    // Enable spans OUTPUT too, giving the crossbar one unbroken window per pass
    assign busy         = (state_q == StLoad) || (state_q == StCompute) || (state_q == StOutput);
    assign done         = (state_q == StDone);
    assign input_ready  = (state_q == StLoad);
    assign xbar_enable  = (state_q == StCompute) || (state_q == StOutput);
    assign output_valid = (state_q == StOutput);
    assign output_data  = res_q;
    assign output_addr  = row_q;
    assign dac_out      = dac_q;
    assign dac_valid    = dac_valid_q;

endmodule

// File: tb/tb_reram_controller.sv
// Randomised bench for reram_controller: a queue-based reference model of the sample
// stream and crossbar answers, checked against DAC and output pulses.
module tb_reram_controller;

    localparam int NIN  = 784;
    localparam int NOUT = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        done, busy, input_ready, dac_valid, xbar_enable, output_valid;
    logic [7:0]  input_data = '0;
    logic        input_valid = 1'b0;
    logic [9:0]  dac_out, xbar_addr;
    logic [11:0] xbar_data, output_data;
    logic        xbar_valid;
    logic [7:0]  output_addr;

    logic        mock_xv = 1'b0, stray_xv = 1'b0;
    logic [11:0] mock_xd = '0, stray_xd = '0;
    assign xbar_valid = mock_xv | stray_xv;
    assign xbar_data  = mock_xv ? mock_xd : stray_xd;

    int total = 0;
    int bad = 0;
    int dac_pulses = 0;
    int out_pulses = 0;
    int exp_row = 0;
    logic [9:0]  exp_dac[$];
    logic [11:0] exp_out[$];

    reram_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
        .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
        .dac_out(dac_out), .dac_valid(dac_valid), .xbar_enable(xbar_enable),
        .xbar_addr(xbar_addr), .xbar_data(xbar_data), .xbar_valid(xbar_valid),
        .output_data(output_data), .output_addr(output_addr), .output_valid(output_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference monitor: every DAC / output pulse is matched against the model queues
    initial begin
        logic [9:0]  ed;
        logic [11:0] eo;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dac_valid) begin
                    dac_pulses++;
                    if (exp_dac.size() == 0) check("dac_extra", 32'(dac_pulses), 32'(0));
                    else begin
                        ed = exp_dac.pop_front();
                        check("dac_out", 32'(dac_out), 32'(ed));
                    end
                end
                if (output_valid) begin
                    out_pulses++;
                    check("out_addr", 32'(output_addr), 32'(exp_row));
                    exp_row++;
                    if (exp_out.size() == 0) check("out_extra", 32'(out_pulses), 32'(0));
                    else begin
                        eo = exp_out.pop_front();
                        check("out_data", 32'(output_data), 32'(eo));
                    end
                end
            end
        end
    end

    // Mock crossbar: answers each row a random number of cycles after it is presented
    initial begin
        int wcnt = 0;
        int lat = 11;
        bit pending = 0;
        forever begin
            @(negedge clk);
            mock_xv = 1'b0;
            if (!rst_n) begin
                pending = 0;
                wcnt = 0;
            end else if (xbar_enable && !output_valid && !pending) begin
                wcnt++;
                if (wcnt >= lat) begin
                    mock_xv = 1'b1;
                    mock_xd = 12'($urandom_range(0, 4095));
                    exp_out.push_back(mock_xd);
                    pending = 1;
                    wcnt = 0;
                    lat = $urandom_range(1, 11);
                end
            end else if (output_valid) begin
                pending = 0;
            end
        end
    end

    // mode 0: 255 at 300..499 else 0, gapped; 1: random back-to-back; 2: random gapped + strays
    task automatic stream(input int mode);
        logic [7:0] s;
        for (int i = 0; i < NIN; i++) begin
            @(negedge clk);
            check("load_addr", 32'(xbar_addr), 32'(i));
            if (mode == 0) s = (i >= 300 && i <= 499) ? 8'd255 : 8'd0;
            else s = 8'($urandom_range(0, 255));
            input_valid = 1'b1;
            input_data = s;
            exp_dac.push_back({s, 2'b00});
            if (mode == 2 && i == 100) begin
                start = 1'b1;
                stray_xv = 1'b1;
                stray_xd = 12'($urandom_range(0, 4095));
            end
            if (mode != 1) begin
                @(negedge clk);
                input_valid = 1'b0;
                start = 1'b0;
                stray_xv = 1'b0;
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end
        if (mode == 1) begin
            // one surplus sample after the last accept must be ignored
            @(negedge clk);
            input_data = 8'hAA;
            check("ready_low", 32'(input_ready), 32'(0));
            @(negedge clk);
            input_valid = 1'b0;
        end
    endtask

    task automatic begin_run();
        dac_pulses = 0;
        out_pulses = 0;
        exp_row = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_load", 32'(busy), 32'(1));
        check("ready_load", 32'(input_ready), 32'(1));
    endtask

    task automatic finish_run();
        int n = 0;
        check("no_early_out", 32'(out_pulses), 32'(0));
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done", 32'(done), 32'(1));
        check("busy_done", 32'(busy), 32'(0));
        check("xen_done", 32'(xbar_enable), 32'(0));
        check("n_dac", 32'(dac_pulses), 32'(NIN));
        check("n_out", 32'(out_pulses), 32'(NOUT));
        check("out_q_empty", 32'(exp_out.size()), 32'(0));
    endtask

    initial begin
        int n;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_ready", 32'(input_ready), 32'(0));
        check("rst_dac", 32'(dac_out), 32'(0));
        check("rst_dacv", 32'(dac_valid), 32'(0));
        check("rst_xen", 32'(xbar_enable), 32'(0));
        check("rst_xaddr", 32'(xbar_addr), 32'(0));
        check("rst_odata", 32'(output_data), 32'(0));
        check("rst_oaddr", 32'(output_addr), 32'(0));
        check("rst_ovalid", 32'(output_valid), 32'(0));
        rst_n = 1'b1;

        begin_run(); stream(0); finish_run();
        begin_run(); stream(1); finish_run();
        begin_run(); stream(2); finish_run();

        // asynchronous reset in the middle of the compute phase
        begin_run(); stream(1);
        n = 0;
        while (out_pulses < 10 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("mid_outs", 32'(out_pulses >= 10), 32'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_xen", 32'(xbar_enable), 32'(0));
        check("arst_odata", 32'(output_data), 32'(0));
        check("arst_oaddr", 32'(output_addr), 32'(0));
        check("arst_dac", 32'(dac_out), 32'(0));
        repeat (3) @(negedge clk);
        exp_dac.delete();
        exp_out.delete();
        rst_n = 1'b1;
        begin_run(); stream(0); finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
